// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret exit sequencer for the multicycle RV32 core.
// Arbitrates exceptions, mret and interrupts; owns MIE/MPIE, mip, mepc, mcause and mtval.
module trap_sequencer #(
    parameter int unsigned XLEN                = 32,
    parameter bit          RESET_MTVEC_MODE_OK = 1'b1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            instr_boundary,
    input  logic [XLEN-1:0] cur_pc,
    input  logic            exc_valid,
    input  logic [3:0]      exc_cause,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            irq_ext,
    input  logic            irq_sw,
    input  logic            irq_timer,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mtvec,
    input  logic            mret_req,
    input  logic            mstatus_we,
    input  logic [XLEN-1:0] mstatus_wdata,
    output logic [XLEN-1:0] mstatus,
    output logic [XLEN-1:0] mip,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause,
    output logic [XLEN-1:0] mtval,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    input  logic            redirect_ack,
    output logic            busy
);

    typedef enum logic [1:0] {StIdle, StSave, StRedir, StRet} state_e;

    state_e          state_q, state_d;
    logic            status_mie_q, status_mie_d;
    logic            status_mpie_q, status_mpie_d;
    logic [2:0]      mip_q;  // {MEIP, MTIP, MSIP}
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [XLEN-1:0] redir_pc_q, redir_pc_d;
    logic            trap_intr_q, trap_intr_d;
    logic [3:0]      trap_code_q, trap_code_d;
    logic [XLEN-1:0] trap_epc_q, trap_epc_d;
    logic [XLEN-1:0] trap_tval_q, trap_tval_d;

    logic [2:0]      pend;
    logic            take_irq;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] target;
    logic            unused;

    assign pend     = mip_q & {mie[11], mie[7], mie[3]};
    assign take_irq = status_mie_q & instr_boundary & (|pend);
    assign base     = {mtvec[XLEN-1:2], 2'b00};
    // Only interrupts are vectored; exceptions always land on the base.
    assign target   = (trap_intr_q && RESET_MTVEC_MODE_OK && (mtvec[1:0] == 2'b01))
                    ? base + {{(XLEN-6){1'b0}}, trap_code_q, 2'b00}
                    : base;
    assign unused   = ^{mie, mstatus_wdata, trap_epc_q[1:0]};

    always_comb begin
        state_d       = state_q;
        status_mie_d  = status_mie_q;
        status_mpie_d = status_mpie_q;
        mepc_d        = mepc_q;
        mcause_d      = mcause_q;
        mtval_d       = mtval_q;
        redir_pc_d    = redir_pc_q;
        trap_intr_d   = trap_intr_q;
        trap_code_d   = trap_code_q;
        trap_epc_d    = trap_epc_q;
        trap_tval_d   = trap_tval_q;

        unique case (state_q)
            StIdle: begin
                if (exc_valid) begin
                    trap_intr_d = 1'b0;
                    trap_code_d = exc_cause;
                    trap_epc_d  = exc_pc;
                    trap_tval_d = exc_tval;
                    state_d     = StSave;
                end else if (mret_req) begin
                    status_mie_d  = status_mpie_q;
                    status_mpie_d = 1'b1;
                    redir_pc_d    = mepc_q;
                    state_d       = StRet;
                end else if (take_irq) begin
                    trap_intr_d = 1'b1;
                    trap_epc_d  = cur_pc;
                    trap_tval_d = '0;
                    if (pend[2]) begin
                        trap_code_d = 4'd11;
                    end else if (pend[0]) begin
                        trap_code_d = 4'd3;
                    end else begin
                        trap_code_d = 4'd7;
                    end
                    state_d = StSave;
                end else if (mstatus_we) begin
                    status_mie_d  = mstatus_wdata[3];
                    status_mpie_d = mstatus_wdata[7];
                end
            end
            StSave: begin
                mepc_d        = {trap_epc_q[XLEN-1:2], 2'b00};
                mcause_d      = {trap_intr_q, {(XLEN-5){1'b0}}, trap_code_q};
                mtval_d       = trap_intr_q ? '0 : trap_tval_q;
                status_mpie_d = status_mie_q;
                status_mie_d  = 1'b0;
                redir_pc_d    = target;
                state_d       = StRedir;
            end
            StRedir, StRet: begin
                if (redirect_ack) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= StIdle;
            status_mie_q  <= 1'b0;
            status_mpie_q <= 1'b0;
            mip_q         <= '0;
            mepc_q        <= '0;
            mcause_q      <= '0;
            mtval_q       <= '0;
            redir_pc_q    <= '0;
            trap_intr_q   <= 1'b0;
            trap_code_q   <= '0;
            trap_epc_q    <= '0;
            trap_tval_q   <= '0;
        end else begin
            state_q       <= state_d;
            status_mie_q  <= status_mie_d;
            status_mpie_q <= status_mpie_d;
            mip_q         <= {irq_ext, irq_timer, irq_sw};
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mtval_q       <= mtval_d;
            redir_pc_q    <= redir_pc_d;
            trap_intr_q   <= trap_intr_d;
            trap_code_q   <= trap_code_d;
            trap_epc_q    <= trap_epc_d;
            trap_tval_q   <= trap_tval_d;
        end
    end

    always_comb begin
        mstatus        = '0;
        mstatus[3]     = status_mie_q;
        mstatus[7]     = status_mpie_q;
        mstatus[12:11] = 2'b11;
        mip            = '0;
        mip[11]        = mip_q[2];
        mip[7]         = mip_q[1];
        mip[3]         = mip_q[0];
    end

    assign mepc           = mepc_q;
    assign mcause         = mcause_q;
    assign mtval          = mtval_q;
    assign redirect_pc    = redir_pc_q;
    assign redirect_valid = (state_q == StRedir) || (state_q == StRet);
    assign busy           = (state_q != StIdle);

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed self-checking bench for trap_sequencer: one task per scenario.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        resetn;
    logic        instr_boundary;
    logic [31:0] cur_pc;
    logic        exc_valid;
    logic [3:0]  exc_cause;
    logic [31:0] exc_pc, exc_tval;
    logic        irq_ext, irq_sw, irq_timer;
    logic [31:0] mie, mtvec;
    logic        mret_req, mstatus_we;
    logic [31:0] mstatus_wdata;
    logic [31:0] mstatus, mip, mepc, mcause, mtval;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ack;
    logic        busy;

    int checks = 0;
    int errors = 0;

    trap_sequencer #(.XLEN(32), .RESET_MTVEC_MODE_OK(1'b1)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .instr_boundary (instr_boundary),
        .cur_pc         (cur_pc),
        .exc_valid      (exc_valid),
        .exc_cause      (exc_cause),
        .exc_pc         (exc_pc),
        .exc_tval       (exc_tval),
        .irq_ext        (irq_ext),
        .irq_sw         (irq_sw),
        .irq_timer      (irq_timer),
        .mie            (mie),
        .mtvec          (mtvec),
        .mret_req       (mret_req),
        .mstatus_we     (mstatus_we),
        .mstatus_wdata  (mstatus_wdata),
        .mstatus        (mstatus),
        .mip            (mip),
        .mepc           (mepc),
        .mcause         (mcause),
        .mtval          (mtval),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ack   (redirect_ack),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mie_bit();
        mstatus_we    = 1'b1;
        mstatus_wdata = 32'h8;
        tick();
        mstatus_we    = 1'b0;
    endtask

    task automatic ack_redirect();
        redirect_ack = 1'b1;
        tick();
        redirect_ack = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %h want 0", busy); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got %h want 0", redirect_valid); end
        checks++; if (mstatus !== 32'h1800) begin errors++; $display("FAIL reset_mstatus got %h want 1800", mstatus); end
        checks++; if ({mip, mepc, mcause, mtval, redirect_pc} !== 160'h0) begin errors++;
            $display("FAIL reset_csrs got %h %h %h %h %h want all 0", mip, mepc, mcause, mtval, redirect_pc); end
        resetn = 1'b1;
        tick();
        write_mie_bit();
        checks++; if (mstatus !== 32'h1808) begin errors++; $display("FAIL mstatus_write got %h want 1808", mstatus); end
    endtask

    task automatic test_timer_direct();
        mie = 32'h80; mtvec = 32'h100; cur_pc = 32'h2004; instr_boundary = 1'b1; irq_timer = 1'b1;
        tick();
        checks++; if (mip !== 32'h80) begin errors++; $display("FAIL timer_mip got %h want 80", mip); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timer_mip_latency got busy %h want 0", busy); end
        tick();
        checks++; if ({busy, redirect_valid} !== 2'b10) begin errors++; $display("FAIL timer_save got %b want 10", {busy, redirect_valid}); end
        tick();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL timer_rv got %h want 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL timer_rpc got %h want 100", redirect_pc); end
        checks++; if (mcause !== 32'h80000007) begin errors++; $display("FAIL timer_mcause got %h want 80000007", mcause); end
        checks++; if (mepc !== 32'h2004) begin errors++; $display("FAIL timer_mepc got %h want 2004", mepc); end
        checks++; if (mtval !== 32'h0) begin errors++; $display("FAIL timer_mtval got %h want 0", mtval); end
        checks++; if (mstatus !== 32'h1880) begin errors++; $display("FAIL timer_mstatus got %h want 1880", mstatus); end
        ack_redirect();
        checks++; if ({busy, redirect_valid} !== 2'b00) begin errors++; $display("FAIL timer_idle got %b want 00", {busy, redirect_valid}); end
    endtask

    task automatic test_mret();
        instr_boundary = 1'b0;
        mret_req = 1'b1;
        tick();
        mret_req = 1'b0;
        checks++; if ({busy, redirect_valid} !== 2'b11) begin errors++; $display("FAIL mret_state got %b want 11", {busy, redirect_valid}); end
        checks++; if (redirect_pc !== 32'h2004) begin errors++; $display("FAIL mret_rpc got %h want 2004", redirect_pc); end
        checks++; if (mstatus !== 32'h1888) begin errors++; $display("FAIL mret_mstatus got %h want 1888", mstatus); end
        ack_redirect();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mret_no_boundary got busy %h want 0", busy); end
        instr_boundary = 1'b1; cur_pc = 32'h2008;
        tick();
        tick();
        checks++; if (mepc !== 32'h2008) begin errors++; $display("FAIL retrap_mepc got %h want 2008", mepc); end
        checks++; if (mcause !== 32'h80000007) begin errors++; $display("FAIL retrap_mcause got %h want 80000007", mcause); end
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL retrap_rv got %h want 1", redirect_valid); end
        irq_timer = 1'b0;
        ack_redirect();
    endtask

    task automatic test_vectored_ext();
        mtvec = 32'h101; mie = 32'h800; irq_ext = 1'b1; cur_pc = 32'h4000;
        write_mie_bit();
        tick();
        tick();
        checks++; if (redirect_pc !== 32'h12C) begin errors++; $display("FAIL vec_rpc got %h want 12c", redirect_pc); end
        checks++; if (mcause !== 32'h8000000B) begin errors++; $display("FAIL vec_mcause got %h want 8000000b", mcause); end
        irq_ext = 1'b0;
        ack_redirect();
    endtask

    task automatic test_exc_priority();
        mtvec = 32'h101; mie = 32'h80; irq_timer = 1'b1;
        write_mie_bit();
        exc_valid = 1'b1; exc_cause = 4'd4; exc_pc = 32'h3000; exc_tval = 32'h4002;
        tick();
        exc_valid = 1'b0;
        tick();
        checks++; if (mcause !== 32'h4) begin errors++; $display("FAIL exc_mcause got %h want 4", mcause); end
        checks++; if (mtval !== 32'h4002) begin errors++; $display("FAIL exc_mtval got %h want 4002", mtval); end
        checks++; if (mepc !== 32'h3000) begin errors++; $display("FAIL exc_mepc got %h want 3000", mepc); end
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL exc_rpc got %h want 100", redirect_pc); end
        ack_redirect();
        tick();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL exc_no_timer got busy %h want 0", busy); end
        checks++; if (mstatus !== 32'h1880) begin errors++; $display("FAIL exc_mstatus got %h want 1880", mstatus); end
        irq_timer = 1'b0;
    endtask

    task automatic test_backpressure();
        mtvec = 32'h200;
        exc_valid = 1'b1; exc_cause = 4'd11; exc_pc = 32'h5004; exc_tval = 32'h0;
        tick();
        exc_valid = 1'b0;
        tick();
        mstatus_we = 1'b1; mstatus_wdata = 32'h8;
        for (int i = 0; i < 5; i++) begin
            checks++; if ({busy, redirect_valid, redirect_pc} !== {2'b11, 32'h200}) begin errors++;
                $display("FAIL bp_hold[%0d] got %b %b %h want 1 1 200", i, busy, redirect_valid, redirect_pc); end
            tick();
        end
        mstatus_we = 1'b0;
        checks++; if (mstatus !== 32'h1800) begin errors++; $display("FAIL bp_mstatus got %h want 1800", mstatus); end
        checks++; if (mcause !== 32'hB) begin errors++; $display("FAIL bp_mcause got %h want b", mcause); end
        ack_redirect();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release got busy %h want 0", busy); end
    endtask

    task automatic test_reset_mid();
        mtvec = 32'h100; mie = 32'h88; irq_sw = 1'b1; irq_timer = 1'b1;
        write_mie_bit();
        tick();
        tick();
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL sw_rv got %h want 1", redirect_valid); end
        checks++; if (mcause !== 32'h80000003) begin errors++; $display("FAIL sw_over_timer got %h want 80000003", mcause); end
        resetn = 1'b0;
        tick();
        checks++; if ({busy, redirect_valid} !== 2'b00) begin errors++; $display("FAIL rmid_state got %b want 00", {busy, redirect_valid}); end
        checks++; if (mstatus !== 32'h1800) begin errors++; $display("FAIL rmid_mstatus got %h want 1800", mstatus); end
        checks++; if ({mip, mepc, mcause, mtval, redirect_pc} !== 160'h0) begin errors++;
            $display("FAIL rmid_csrs got %h %h %h %h %h want all 0", mip, mepc, mcause, mtval, redirect_pc); end
        resetn = 1'b1;
        tick();
        tick();
        checks++; if (mip !== 32'h88) begin errors++; $display("FAIL rmid_mip got %h want 88", mip); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_no_trap got busy %h want 0", busy); end
        irq_sw = 1'b0; irq_timer = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; instr_boundary = 1'b0; cur_pc = '0;
        exc_valid = 1'b0; exc_cause = '0; exc_pc = '0; exc_tval = '0;
        irq_ext = 1'b0; irq_sw = 1'b0; irq_timer = 1'b0;
        mie = '0; mtvec = '0; mret_req = 1'b0; mstatus_we = 1'b0; mstatus_wdata = '0;
        redirect_ack = 1'b0;
        #2;
        test_reset();
        test_timer_direct();
        test_mret();
        test_vectored_ext();
        test_exc_priority();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
